ngc_fifo_wr_arbiter: RTL and testbench

//  Shares the single push port of one ngc_fifo among NUM_REQ writers.
//  - Round-robin grant; holding the grant across multi-beat bursts (req_last-delimited, capped at MAX_BURST).
//  - Drives fifo_push/fifo_din, gated by fifo_full.
//  - Sits between producer blocks and the FIFO slave; pop side is untouched.

---
 rtl/ngc_fifo_pkg.sv | 19 +
 rtl/ngc_rr_picker.sv | 39 +++
 rtl/ngc_fifo_wr_arbiter.sv | 99 +++++++++
 tb/tb_ngc_fifo_wr_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ngc_fifo_pkg.sv
// rtl/ngc_fifo_pkg.sv - shared types and width helpers for the ngc_fifo write arbiter
package ngc_fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Index width for n requesters; never collapses to zero bits.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Burst counter width wide enough to hold max_burst itself.
  function automatic int cnt_w(input int max_burst);
    return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
  endfunction

endpackage

// File: rtl/ngc_rr_picker.sv
// rtl/ngc_rr_picker.sv - rotating priority encoder: first set request at or above start, with wrap
module ngc_rr_picker
  import ngc_fifo_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] start_i,
  output logic          found_o,
  output logic [PW-1:0] idx_o
);

  logic          found_hi;
  logic          found_lo;
  logic [PW-1:0] idx_hi;
  logic [PW-1:0] idx_lo;

  // Descending scans leave the lowest qualifying index; the high pass wins over the wrapped pass.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req_i[j] && (PW'(j) >= start_i)) begin
        found_hi = 1'b1;
        idx_hi   = PW'(j);
      end
      if (req_i[j]) begin
        found_lo = 1'b1;
        idx_lo   = PW'(j);
      end
    end
    found_o = found_hi | found_lo;
    idx_o   = found_hi ? idx_hi : idx_lo;
  end

endmodule

// File: rtl/ngc_fifo_wr_arbiter.sv
// rtl/ngc_fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO push port among NUM_REQ writers
module ngc_fifo_wr_arbiter
  import ngc_fifo_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          fifo_push_o,
  output logic [DATA_WIDTH-1:0]         fifo_din_o,
  input  logic                          fifo_full_i,
  output logic [ptr_w(NUM_REQ)-1:0]     grant_id_o,
  output logic                          busy_o
);

  localparam int PW = ptr_w(NUM_REQ);
  localparam int CW = cnt_w(MAX_BURST);

  arb_state_t    state_q;
  logic [PW-1:0] grant_q;
  logic [PW-1:0] rr_ptr_q;
  logic [PW-1:0] rr_ptr_d;
  logic [CW-1:0] beat_cnt_q;
  logic          busy_q;

  logic          pick_found;
  logic [PW-1:0] pick_idx;
  logic          can_take;
  logic          accept;
  logic          release_grant;

  ngc_rr_picker #(
    .N (NUM_REQ),
    .PW(PW)
  ) u_picker (
    .req_i  (req_valid_i),
    .start_i(rr_ptr_q),
    .found_o(pick_found),
    .idx_o  (pick_idx)
  );

  // The reset term keeps a truncated burst from pushing during the reset cycle itself.
  always_comb begin
    can_take      = (state_q == GRANT) && !fifo_full_i && !rst;
    accept        = can_take && req_valid_i[grant_q];
    release_grant = accept && (req_last_i[grant_q] || (beat_cnt_q == CW'(MAX_BURST - 1)));
    rr_ptr_d      = (grant_q == PW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    req_ready_o   = '0;
    if (can_take) begin
      req_ready_o[grant_q] = 1'b1;
    end
    fifo_push_o = accept;
    fifo_din_o  = busy_q ? req_data_i[grant_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q <= GRANT;
            grant_q <= pick_idx;
            busy_q  <= 1'b1;
          end
        end
        GRANT: begin
          if (release_grant) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= '0;
          end else if (accept) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant_id_o = grant_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_ngc_fifo_wr_arbiter.sv
// tb/tb_ngc_fifo_wr_arbiter.sv - directed self-checking bench for ngc_fifo_wr_arbiter
module tb_ngc_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_push;
  logic [7:0]  fifo_din;
  logic        fifo_full;
  logic [1:0]  grant_id;
  logic        busy;

  int n_cmp;
  int n_err;

  ngc_fifo_wr_arbiter #(
    .NUM_REQ   (4),
    .DATA_WIDTH(8),
    .MAX_BURST (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid_i(req_valid),
    .req_data_i (req_data),
    .req_last_i (req_last),
    .req_ready_o(req_ready),
    .fifo_push_o(fifo_push),
    .fifo_din_o (fifo_din),
    .fifo_full_i(fifo_full),
    .grant_id_o (grant_id),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_data(input int i, input logic [7:0] v);
    req_data[i*8 +: 8] = v;
  endtask

  task automatic chk_beat(input string tag, input logic [1:0] g, input logic [7:0] d);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_gid"}, 32'(grant_id), 32'(g));
    chk({tag, "_push"}, 32'(fifo_push), 32'd1);
    chk({tag, "_din"}, 32'(fifo_din), 32'(d));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_push"}, 32'(fifo_push), 32'd0);
    chk({tag, "_rdy"}, 32'(req_ready), 32'd0);
  endtask

  logic [1:0] order [5];

  initial begin
    n_cmp = 0;
    n_err = 0;
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;

    // Reset with every requester asking
    rst = 1'b1; req_valid = 4'hF; req_last = 4'h0; req_data = '0; fifo_full = 1'b0;
    for (int c = 0; c < 2; c++) begin
      cyc();
      chk_quiet("rst");
      chk("rst_gid", 32'(grant_id), 32'd0);
      chk("rst_din", 32'(fifo_din), 32'd0);
    end

    // Single requester, 3-beat burst
    rst = 1'b0; req_valid = 4'b0001; req_last = 4'b0000; set_data(0, 8'hA1);
    settle();
    chk_quiet("t2_idle");
    cyc();
    chk_beat("t2_b0", 2'd0, 8'hA1);
    chk("t2_rdy", 32'(req_ready), 32'b0001);
    cyc();
    set_data(0, 8'hA2); settle();
    chk_beat("t2_b1", 2'd0, 8'hA2);
    cyc();
    set_data(0, 8'hA3); req_last = 4'b0001; settle();
    chk_beat("t2_b2", 2'd0, 8'hA3);
    cyc();
    req_valid = 4'b0011; req_last = 4'b0011; set_data(0, 8'hD0); set_data(1, 8'hD1); settle();
    chk_quiet("t2_rel");
    cyc();
    chk_beat("t2_ptr1", 2'd1, 8'hD1);
    chk("t2_ptr1_rdy", 32'(req_ready), 32'b0010);
    cyc();

    // Fresh reset, then all four with 1-beat bursts
    rst = 1'b1; cyc();
    rst = 1'b0; req_valid = 4'hF; req_last = 4'hF;
    for (int i = 0; i < 4; i++) set_data(i, 8'hB0 + 8'(i));
    settle(); cyc();
    for (int k = 0; k < 5; k++) begin
      chk_beat($sformatf("t3_g%0d", k), order[k], 8'hB0 + 8'(order[k]));
      cyc();
      if (k == 4) begin
        req_valid = 4'b0010; req_last = 4'b0010;
        settle();
      end
      chk_quiet($sformatf("t3_bub%0d", k));
      if (k != 4) cyc();
    end

    // Move ptr to 2 via req1, then req2 runs into the burst cap
    cyc();
    req_valid = 4'b0110; req_last = 4'b0010; set_data(1, 8'hE1); set_data(2, 8'hC0); settle();
    chk_beat("t4_r1", 2'd1, 8'hE1);
    cyc();
    chk_quiet("t4_bub");
    cyc();
    for (int b = 0; b < 4; b++) begin
      set_data(2, 8'hC0 + 8'(b)); settle();
      chk_beat($sformatf("t4_c%0d", b), 2'd2, 8'hC0 + 8'(b));
      cyc();
    end
    chk_quiet("t4_cap");
    cyc();
    chk_beat("t4_next", 2'd1, 8'hE1);
    req_valid = 4'b0010; req_last = 4'b0010;
    cyc();

    // fifo_full stall mid-burst, ptr now 2
    req_valid = 4'b0100; req_last = 4'b0000; set_data(2, 8'hF0); settle();
    cyc();
    chk_beat("t5_f0", 2'd2, 8'hF0);
    cyc();
    set_data(2, 8'hF1); fifo_full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk($sformatf("t5_full%0d_push", c), 32'(fifo_push), 32'd0);
      chk($sformatf("t5_full%0d_rdy", c), 32'(req_ready), 32'd0);
      chk($sformatf("t5_full%0d_busy", c), 32'(busy), 32'd1);
      cyc();
    end
    fifo_full = 1'b0; settle();
    chk_beat("t5_f1", 2'd2, 8'hF1);
    cyc();
    set_data(2, 8'hF2); settle();
    chk_beat("t5_f2", 2'd2, 8'hF2);
    cyc();
    set_data(2, 8'hF3); settle();
    chk_beat("t5_f3", 2'd2, 8'hF3);
    cyc();
    req_valid = 4'b0000; settle();
    chk_quiet("t5_rel");

    // Reset after two beats of a burst; ptr was 3
    req_valid = 4'b1000; set_data(3, 8'h91); settle();
    cyc();
    chk_beat("t6_b0", 2'd3, 8'h91);
    cyc();
    set_data(3, 8'h92); settle();
    chk_beat("t6_b1", 2'd3, 8'h92);
    cyc();
    rst = 1'b1; set_data(3, 8'h93); settle();
    chk("t6_rstcyc_push", 32'(fifo_push), 32'd0);
    cyc();
    rst = 1'b0; req_valid = 4'b1001; set_data(0, 8'h55); settle();
    chk_quiet("t6_after");
    chk("t6_after_gid", 32'(grant_id), 32'd0);
    cyc();
    chk_beat("t6_ptr0", 2'd0, 8'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
